// File: rtl/if_fetch_pkg.sv
// Shared definitions for the simplemips instruction-fetch front end:
// redirect polarity, FSM state encodings and the exception filler word.
package if_fetch_pkg;

    localparam logic        BRANCH        = 1'b1;
    localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_WAIT,
        IF_DISCARD,
        IF_HOLD
    } if_state_e;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end: one req/ack bus read per PC, a single skid
// entry for IF/ID back-pressure, redirect kill and misaligned-PC flagging.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_flag,
    input  logic              id_stall,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_ack,
    input  logic [DATA_W-1:0] ibus_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_excp_adel,
    output logic              stall_req
);

    if_state_e state, state_next;

    logic redirect;
    logic aligned;
    logic issue, retire;
    logic out_from_bus, out_from_adel, out_from_skid;
    logic skid_from_bus, skid_from_adel, skid_kill;

    logic              skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;
    logic              skid_adel;

    assign redirect  = (branch_flag == BRANCH);
    assign aligned   = word_aligned(pc[1:0]);
    assign stall_req = (state != IF_IDLE) | (aligned & ~redirect);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IF_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next     = state;
        issue          = 1'b0;
        retire         = 1'b0;
        out_from_bus   = 1'b0;
        out_from_adel  = 1'b0;
        out_from_skid  = 1'b0;
        skid_from_bus  = 1'b0;
        skid_from_adel = 1'b0;
        skid_kill      = 1'b0;
        unique case (state)
            IF_IDLE: begin
                // During a redirect the PC still holds the stale address.
                if (!redirect) begin
                    if (aligned) begin
                        issue      = 1'b1;
                        state_next = IF_WAIT;
                    end else if (!id_stall) begin
                        out_from_adel = 1'b1;
                    end else begin
                        skid_from_adel = 1'b1;
                        state_next     = IF_HOLD;
                    end
                end
            end
            IF_WAIT: begin
                if (ibus_ack) begin
                    retire = 1'b1;
                    if (redirect) begin
                        state_next = IF_IDLE;
                    end else if (!id_stall) begin
                        out_from_bus = 1'b1;
                        state_next   = IF_IDLE;
                    end else begin
                        skid_from_bus = 1'b1;
                        state_next    = IF_HOLD;
                    end
                end else if (redirect) begin
                    state_next = IF_DISCARD;
                end
            end
            IF_DISCARD: begin
                if (ibus_ack) begin
                    retire     = 1'b1;
                    state_next = IF_IDLE;
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    skid_kill  = 1'b1;
                    state_next = IF_IDLE;
                end else if (!id_stall) begin
                    out_from_skid = 1'b1;
                    skid_kill     = 1'b1;
                    state_next    = IF_IDLE;
                end
            end
            default: state_next = IF_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ibus_req  <= 1'b0;
            ibus_addr <= '0;
        end else if (issue) begin
            ibus_req  <= 1'b1;
            ibus_addr <= pc;
        end else if (retire) begin
            ibus_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_inst      <= '0;
            id_excp_adel <= 1'b0;
        end else if (out_from_bus) begin
            id_valid     <= 1'b1;
            id_pc        <= ibus_addr;
            id_inst      <= ibus_rdata;
            id_excp_adel <= 1'b0;
        end else if (out_from_adel) begin
            id_valid     <= 1'b1;
            id_pc        <= pc;
            id_inst      <= NOP_INST;
            id_excp_adel <= 1'b1;
        end else if (out_from_skid) begin
            id_valid     <= skid_valid;
            id_pc        <= skid_pc;
            id_inst      <= skid_inst;
            id_excp_adel <= skid_adel;
        end else if (redirect) begin
            id_valid     <= 1'b0;
            id_excp_adel <= 1'b0;
        end else if (!id_stall) begin
            id_valid     <= 1'b0;
        end
    end

    // The skid entry is only a handful of flops, so it is cleared on reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            skid_adel  <= 1'b0;
        end else if (skid_from_bus) begin
            skid_valid <= 1'b1;
            skid_pc    <= ibus_addr;
            skid_inst  <= ibus_rdata;
            skid_adel  <= 1'b0;
        end else if (skid_from_adel) begin
            skid_valid <= 1'b1;
            skid_pc    <= pc;
            skid_inst  <= NOP_INST;
            skid_adel  <= 1'b1;
        end else if (skid_kill) begin
            skid_valid <= 1'b0;
        end
    end

endmodule
